instr_encoder_loader: RTL and testbench

- Boot-time writer for the pipeline's instruction memory; the encoding counterpart of the instruction decoder/control unit.
- Accepts assembled operations (mnemonic plus register/immediate fields) over a valid/ready handshake.
- Packs each operation into the 32-bit instruction word the decoder consumes and writes the words sequentially into IMEM.
- Holds the CPU in reset until the program load completes.

---
 rtl/isa_pkg.sv | 63 ++++++
 rtl/instr_encoder_loader_if.sv | 37 +++
 rtl/instr_packer.sv | 48 ++++
 rtl/instr_encoder_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the loader, its packer and the bench model.
// Field positions and err_code values also apply to the READBACK_VERIFY_EN build.
package isa_pkg;

    typedef enum logic [3:0] {
        MN_SUM    = 4'd0,
        MN_DAT1   = 4'd1,
        MN_DAT2   = 4'd2,
        MN_DAT3   = 4'd3,
        MN_RSD    = 4'd4,
        MN_SUMI   = 4'd5,
        MN_DAT1I  = 4'd6,
        MN_DAT2I  = 4'd7,
        MN_DAT3I  = 4'd8,
        MN_RSDI   = 4'd9,
        MN_SI     = 4'd10,
        MN_SCI    = 4'd11,
        MN_SCD    = 4'd12,
        MN_GDR    = 4'd13,
        MN_CRG    = 4'd14,
        MN_ILLEGAL = 4'd15
    } mnemonic_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_MEM  = 2'b01;
    localparam logic [1:0] TYPE_CTRL = 2'b00;

    localparam logic [4:0] FUNC_DATA_RR_BASE  = 5'b00000;
    localparam logic [4:0] FUNC_DATA_IMM_BASE = 5'b11000;
    localparam logic [4:0] FUNC_SI  = 5'b00000;
    localparam logic [4:0] FUNC_SCI = 5'b00010;
    localparam logic [4:0] FUNC_SCD = 5'b00011;
    localparam logic [4:0] FUNC_GDR = 5'b00000;
    localparam logic [4:0] FUNC_CRG = 5'b00001;

    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned TYPE_LSB = 30;
    localparam int unsigned FUNC_MSB = 29;
    localparam int unsigned FUNC_LSB = 25;
    localparam int unsigned F1_MSB   = 24;
    localparam int unsigned F1_LSB   = 21;
    localparam int unsigned F2_MSB   = 20;
    localparam int unsigned F2_LSB   = 17;
    localparam int unsigned F3_MSB   = 16;
    localparam int unsigned F3_LSB   = 13;
    localparam int unsigned IMM_MSB  = 16;
    localparam int unsigned IMM_LSB  = 0;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_VERIFY   = 2'b11;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Operation handshake plus IMEM write bus of the loader.
// READBACK_VERIFY_EN adds imem_rdata driven by the memory side.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        mnemonic;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [16:0]       imm;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
`ifdef READBACK_VERIFY_EN
    logic [31:0]       imem_rdata;
`endif

    modport slave (
        input  op_valid, mnemonic, rd, rs1, rs2, imm, last,
`ifdef READBACK_VERIFY_EN
        input  imem_rdata,
`endif
        output op_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output op_valid, mnemonic, rd, rs1, rs2, imm, last,
`ifdef READBACK_VERIFY_EN
        output imem_rdata,
`endif
        input  op_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_packer.sv
// Combinational mnemonic + register/immediate fields -> {legal, 32-bit instruction word}.
module instr_packer
    import isa_pkg::*;
(
    input  logic [3:0]  mnemonic_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rs1_i,
    input  logic [3:0]  rs2_i,
    input  logic [16:0] imm_i,
    output logic        legal_o,
    output logic [31:0] word_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        if (mnemonic_i <= MN_RSD) begin
            word_o[TYPE_MSB:TYPE_LSB] = TYPE_DATA;
            word_o[FUNC_MSB:FUNC_LSB] = FUNC_DATA_RR_BASE + 5'(mnemonic_i);
            word_o[F1_MSB:F1_LSB]     = rd_i;
            word_o[F2_MSB:F2_LSB]     = rs1_i;
            word_o[F3_MSB:F3_LSB]     = rs2_i;
        end else if (mnemonic_i <= MN_RSDI) begin
            word_o[TYPE_MSB:TYPE_LSB] = TYPE_DATA;
            word_o[FUNC_MSB:FUNC_LSB] = FUNC_DATA_IMM_BASE + 5'(mnemonic_i - MN_SUMI);
            word_o[F1_MSB:F1_LSB]     = rd_i;
            word_o[F2_MSB:F2_LSB]     = rs1_i;
            word_o[IMM_MSB:IMM_LSB]   = imm_i;
        end else if (mnemonic_i <= MN_SCD) begin
            // control words carry the two compared sources in the upper field slots
            word_o[TYPE_MSB:TYPE_LSB] = TYPE_CTRL;
            word_o[FUNC_MSB:FUNC_LSB] = (mnemonic_i == MN_SI)  ? FUNC_SI :
                                        (mnemonic_i == MN_SCI) ? FUNC_SCI : FUNC_SCD;
            word_o[F1_MSB:F1_LSB]     = rs1_i;
            word_o[F2_MSB:F2_LSB]     = rs2_i;
            word_o[IMM_MSB:IMM_LSB]   = imm_i;
        end else if (mnemonic_i <= MN_CRG) begin
            word_o[TYPE_MSB:TYPE_LSB] = TYPE_MEM;
            word_o[FUNC_MSB:FUNC_LSB] = (mnemonic_i == MN_GDR) ? FUNC_GDR : FUNC_CRG;
            word_o[F1_MSB:F1_LSB]     = rd_i;
            word_o[F2_MSB:F2_LSB]     = rs1_i;
            word_o[IMM_MSB:IMM_LSB]   = imm_i;
        end else begin
            legal_o = 1'b0;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes handshaken operations and writes them sequentially into IMEM,
// holding the CPU in reset until done. READBACK_VERIFY_EN adds a two-cycle readback check.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   cpu_rst,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic [1:0]        err_code_q, err_code_d;
`ifdef READBACK_VERIFY_EN
    logic              vphase_q, vphase_d;
`endif

    logic              legal;
    logic [31:0]       word;
    logic              accept;
    state_e            exit_state;
    logic [ADDR_W-1:0] exit_addr;
    logic [1:0]        exit_code;

    instr_packer u_packer (
        .mnemonic_i (bus.mnemonic),
        .rd_i       (bus.rd),
        .rs1_i      (bus.rs1),
        .rs2_i      (bus.rs2),
        .imm_i      (bus.imm),
        .legal_o    (legal),
        .word_o     (word)
    );

    // start takes priority over a same-cycle operation
    assign accept = (state_q == ST_LOAD) && bus.op_valid && !start;

    // decision taken once a word is committed (after WRITE, or after a clean VERIFY)
    always_comb begin
        exit_state = ST_LOAD;
        exit_addr  = addr_q + ADDR_W'(1);
        exit_code  = err_code_q;
        if (last_q) begin
            exit_state = ST_DONE;
            exit_addr  = addr_q;
        end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
            exit_state = ST_ERROR;
            exit_addr  = addr_q;
            exit_code  = ERR_OVERFLOW;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_d       = last_q;
        err_code_d   = err_code_q;
`ifdef READBACK_VERIFY_EN
        vphase_d     = vphase_q;
`endif
        bus.op_ready = 1'b0;
        bus.imem_we  = 1'b0;
        cpu_rst      = 1'b1;
        done         = 1'b0;
        err          = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                bus.op_ready = 1'b1;
                if (accept) begin
                    if (legal) begin
                        wdata_d = word;
                        last_d  = bus.last;
                        state_d = ST_WRITE;
                    end else begin
                        err_code_d = ERR_ILLEGAL;
                        state_d    = ST_ERROR;
                    end
                end
            end
            ST_WRITE: begin
                bus.imem_we = 1'b1;
`ifdef READBACK_VERIFY_EN
                vphase_d = 1'b0;
                state_d  = ST_VERIFY;
`else
                state_d    = exit_state;
                addr_d     = exit_addr;
                err_code_d = exit_code;
`endif
            end
            ST_VERIFY: begin
`ifdef READBACK_VERIFY_EN
                // first cycle only lets the read data settle; compare on the second
                if (!vphase_q) begin
                    vphase_d = 1'b1;
                end else if (bus.imem_rdata != wdata_q) begin
                    err_code_d = ERR_VERIFY;
                    state_d    = ST_ERROR;
                end else begin
                    state_d    = exit_state;
                    addr_d     = exit_addr;
                    err_code_d = exit_code;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d    = ST_LOAD;
            addr_d     = '0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef READBACK_VERIFY_EN
            vphase_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            err_code_q <= err_code_d;
`ifdef READBACK_VERIFY_EN
            vphase_q   <= vphase_d;
`endif
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against an arithmetic reference model.
// With READBACK_VERIFY_EN it also models the IMEM read port and a corrupted readback.
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        logic [3:0]  mn;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [16:0] imm;
        logic        last;
    } op_s;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cpu_rst, done, err;
    logic [1:0] err_code;
    logic       corrupt = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    op_s               prog[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

`ifdef READBACK_VERIFY_EN
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q = '0;
    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) mem[bus.imem_addr[1:0]] <= bus.imem_wdata;
        rdata_q <= mem[bus.imem_addr[1:0]] ^ {31'd0, corrupt};
    end
    assign bus.imem_rdata = rdata_q;
`endif

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {legal, word} from the instruction-format rules, using plain arithmetic
    function automatic logic [32:0] ref_encode(input op_s o);
        int unsigned m, ty, fn, a, b, c;
        m = int'(o.mn);
        if (m == 15) return 33'd0;
        if (m < 5) begin
            ty = 2; fn = m;      a = o.rd;  b = o.rs1; c = int'(o.rs2) * 8192;
        end else if (m < 10) begin
            ty = 2; fn = 24 + m - 5; a = o.rd; b = o.rs1; c = o.imm;
        end else if (m < 13) begin
            ty = 0; fn = (m == 10) ? 0 : (m == 11) ? 2 : 3;
            a = o.rs1; b = o.rs2; c = o.imm;
        end else begin
            ty = 1; fn = m - 13; a = o.rd;  b = o.rs1; c = o.imm;
        end
        return {1'b1, 32'(ty * (1 << 30) + fn * (1 << 25) + a * (1 << 21) + b * (1 << 17) + c)};
    endfunction

    function automatic op_s mk(input int mn, input int rd, input int rs1, input int rs2,
                               input int imm, input bit last);
        op_s o;
        o.mn = 4'(mn); o.rd = 4'(rd); o.rs1 = 4'(rs1); o.rs2 = 4'(rs2);
        o.imm = 17'(imm); o.last = last;
        return o;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_op(input op_s o, output bit acc);
        acc = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (bus.op_ready === 1'b1) begin
                bus.mnemonic = o.mn; bus.rd = o.rd; bus.rs1 = o.rs1;
                bus.rs2 = o.rs2; bus.imm = o.imm; bus.last = o.last;
                bus.op_valid = 1'b1;
                @(negedge clk);
                bus.op_valid = 1'b0;
                acc = 1'b1;
                check("ready_drop", 32'(bus.op_ready), 32'd0);
                check("write_latency", 32'(bus.imem_we), (o.mn == 4'hF) ? 32'd0 : 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_prog();
        logic [31:0] ew[$];
        logic [32:0] enc;
        bit          exp_done, acc;
        logic [1:0]  exp_code;
        int          end_idx;
        exp_done = 1'b0; exp_code = 2'b00; end_idx = prog.size() - 1;
        for (int i = 0; i < prog.size(); i++) begin
            enc = ref_encode(prog[i]);
            if (!enc[32]) begin exp_code = 2'b01; end_idx = i; break; end
            ew.push_back(enc[31:0]);
`ifdef READBACK_VERIFY_EN
            if (corrupt) begin exp_code = 2'b11; end_idx = i; break; end
`endif
            if (prog[i].last) begin exp_done = 1'b1; end_idx = i; break; end
            if (i == int'(DEPTH) - 1) begin exp_code = 2'b10; end_idx = i; break; end
        end
        wa.delete(); wd.delete();
        pulse_start();
        check("start_cpu_rst", 32'(cpu_rst), 32'd1);
        for (int i = 0; i < prog.size(); i++) begin
            send_op(prog[i], acc);
            check("accepted", 32'(acc), 32'(i <= end_idx));
        end
        for (int t = 0; t < 30 && !(done || err); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("n_writes", 32'(wa.size()), 32'(ew.size()));
        for (int i = 0; i < wa.size() && i < ew.size(); i++) begin
            check("waddr", 32'(wa[i]), 32'(i));
            check("wdata", wd[i], ew[i]);
        end
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("err_code", 32'(err_code), 32'(exp_code));
        check("cpu_rst", 32'(cpu_rst), 32'(!exp_done));
        check("idle_ready", 32'(bus.op_ready), 32'd0);
    endtask

    initial begin
        bit acc;
        bus.op_valid = 1'b0; bus.mnemonic = '0; bus.rd = '0; bus.rs1 = '0;
        bus.rs2 = '0; bus.imm = '0; bus.last = 1'b0;
        #12;
        check("rst_ready", 32'(bus.op_ready), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        prog = '{mk(0, 3, 1, 2, 0, 0), mk(5, 1, 0, 0, 5, 0), mk(14, 4, 2, 0, 8, 1)};
        run_prog();
        if (wd.size() == 3) begin
            check("vec_sum", wd[0], 32'h80624000);
            check("vec_sumi", wd[1], 32'hB0200005);
            check("vec_crg", wd[2], 32'h42840008);
        end else check("vec_count", 32'(wd.size()), 32'd3);

        prog = '{mk(10, 0, 0, 0, 'h10, 0), mk(11, 0, 1, 2, 4, 1)};
        run_prog();
        if (wd.size() == 2) begin
            check("vec_si", wd[0], 32'h00000010);
            check("vec_sci", wd[1], 32'h04240004);
        end else check("vec_count2", 32'(wd.size()), 32'd2);

        prog = '{mk(15, 1, 2, 3, 4, 0)};
        run_prog();
        prog = '{mk(1, 7, 6, 5, 0, 0), mk(3, 2, 2, 2, 0, 0), mk(13, 9, 8, 0, 99, 0),
                 mk(12, 0, 3, 4, 77, 0), mk(2, 1, 1, 1, 0, 1)};
        run_prog();
        prog.delete(prog.size() - 1);
        prog[3].last = 1'b1;
        run_prog();

        // start and op_valid together: start wins, the op is dropped
        wa.delete(); wd.delete();
        pulse_start();
        start = 1'b1; bus.op_valid = 1'b1; bus.mnemonic = 4'd4; bus.last = 1'b0;
        @(negedge clk);
        start = 1'b0; bus.op_valid = 1'b0;
        check("collide_we", 32'(bus.imem_we), 32'd0);
        check("collide_ready", 32'(bus.op_ready), 32'd1);
        send_op(mk(10, 0, 0, 0, 3, 1), acc);
        repeat (6) @(negedge clk);
        check("collide_nw", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) check("collide_addr", 32'(wa[0]), 32'd0);
        check("collide_done", 32'(done), 32'd1);

        // async reset in the middle of a write strobe
        pulse_start();
        bus.mnemonic = 4'd6; bus.rd = 4'd5; bus.imm = 17'h1ABCD; bus.last = 1'b0;
        bus.op_valid = 1'b1;
        @(posedge clk); #2;
        bus.op_valid = 1'b0;
        check("pre_rst_we", 32'(bus.imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.imem_we), 32'd0);
        check("arst_addr", 32'(bus.imem_addr), 32'd0);
        check("arst_wdata", bus.imem_wdata, 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_ready", 32'(bus.op_ready), 32'd0);
        check("arst_code", 32'(err_code), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int r = 0; r < 40; r++) begin
            int n;
            op_s o;
            prog.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                o = mk(($urandom_range(0, 24) == 0) ? 15 : $urandom_range(0, 14),
                       $urandom, $urandom, $urandom, $urandom, i == n - 1);
                prog.push_back(o);
            end
            run_prog();
        end

`ifdef READBACK_VERIFY_EN
        corrupt = 1'b1;
        prog = '{mk(0, 1, 2, 3, 0, 1)};
        run_prog();
        corrupt = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
